apb_motor_ramp_ctrl: RTL and testbench



---
 rtl/apb_motor_ramp_if.sv | 22 ++
 rtl/apb_motor_ramp_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_apb_motor_ramp_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_motor_ramp_if.sv
// APB3 bus bundle for apb_motor_ramp_ctrl. The master drives the request
// fields and the slave returns read data and the response.
interface apb_motor_ramp_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_motor_ramp_ctrl.sv
// APB3 motor command block: per-channel duty slew limiting, reverse-through-zero and a watchdog.
// Define APB_MOTOR_SLVERR_EN to return PSLVERR on unmapped words and on channel writes while tripped.
module apb_motor_ramp_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int DUTY_W      = 8,
  parameter int TIMEOUT_CYC = 100000000,
  parameter int RAMP_DIV    = 1000,
  parameter int RAMP_STEP   = 1
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  apb_motor_ramp_if.slave          apb,
  output logic [NUM_CH*DUTY_W-1:0] PWM_DUTY,
  output logic [NUM_CH-1:0]        PWM_EN,
  output logic [NUM_CH-1:0]        PWM_DIR,
  output logic                     WDOG_TRIP
);

  localparam int TK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  localparam logic [TK_W-1:0]   TK_LAST     = TK_W'(RAMP_DIV - 1);
  localparam logic [WD_W-1:0]   WD_LAST     = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [DUTY_W-1:0] STEP        = DUTY_W'(RAMP_STEP);
  localparam logic [5:0]        STATUS_WORD = 6'd15;

  // Move d toward t by at most STEP without overshooting.
  function automatic logic [DUTY_W-1:0] slew(input logic [DUTY_W-1:0] d,
                                             input logic [DUTY_W-1:0] t);
    logic [DUTY_W-1:0] gap;
    if (d < t) begin
      gap  = t - d;
      slew = d + ((gap < STEP) ? gap : STEP);
    end else begin
      gap  = d - t;
      slew = d - ((gap < STEP) ? gap : STEP);
    end
  endfunction

  logic [TK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              trip_q, trip_d;
  logic [NUM_CH-1:0] en_t_q, en_t_d;
  logic [NUM_CH-1:0] dir_t_q, dir_t_d;
  logic [NUM_CH-1:0] dir_q, dir_d;
  logic [DUTY_W-1:0] duty_t_q [NUM_CH];
  logic [DUTY_W-1:0] duty_t_d [NUM_CH];
  logic [DUTY_W-1:0] duty_q   [NUM_CH];
  logic [DUTY_W-1:0] duty_d   [NUM_CH];

  logic [5:0]        word;
  logic              wr_en, rd_en, ch_hit, st_hit, ch_wr, st_clr, tick;
  logic [NUM_CH-1:0] busy;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign word   = apb.PADDR[7:2];
  assign wr_en  = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign rd_en  = apb.PSEL & ~apb.PWRITE;
  assign ch_hit = (word < 6'(NUM_CH));
  assign st_hit = (word == STATUS_WORD);
  assign ch_wr  = wr_en & ch_hit & ~trip_q;
  assign st_clr = wr_en & st_hit & apb.PWDATA[0];
  assign tick   = (tick_cnt_q == TK_LAST);

  assign unused_bits = ^{apb.PADDR[31:8], apb.PADDR[1:0],
                         apb.PWDATA[31:8+DUTY_W], apb.PWDATA[7:2]};

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    wd_cnt_d   = wd_cnt_q;
    trip_d     = trip_q;
    en_t_d     = en_t_q;
    dir_t_d    = dir_t_q;
    dir_d      = dir_q;
    duty_t_d   = duty_t_q;
    duty_d     = duty_q;

    // Ramp on tick using the targets held before this edge's write.
    for (int c = 0; c < NUM_CH; c++) begin
      if (tick) begin
        if (dir_q[c] != dir_t_q[c]) begin
          if (duty_q[c] != '0) duty_d[c] = slew(duty_q[c], '0);
          else                 dir_d[c]  = dir_t_q[c];
        end else begin
          duty_d[c] = slew(duty_q[c], duty_t_q[c]);
        end
      end
      // A disabled channel parks at zero so re-enabling always ramps from rest.
      if (!en_t_q[c]) duty_d[c] = '0;
      if (ch_wr && word == 6'(c)) begin
        en_t_d[c]   = apb.PWDATA[0];
        dir_t_d[c]  = apb.PWDATA[1];
        duty_t_d[c] = apb.PWDATA[8 +: DUTY_W];
        if (!apb.PWDATA[0]) duty_d[c] = '0;
      end
    end

    // Watchdog; a trip overrides everything above, with no ramp-down.
    if (trip_q) begin
      if (st_clr) begin
        trip_d   = 1'b0;
        wd_cnt_d = '0;
      end
    end else if (ch_wr) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q == WD_LAST) begin
      trip_d  = 1'b1;
      en_t_d  = '0;
      dir_t_d = '0;
      dir_d   = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        duty_t_d[c] = '0;
        duty_d[c]   = '0;
      end
    end else begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tick_cnt_q <= '0;
      wd_cnt_q   <= '0;
      trip_q     <= 1'b0;
      en_t_q     <= '0;
      dir_t_q    <= '0;
      dir_q      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        duty_t_q[c] <= '0;
        duty_q[c]   <= '0;
      end
    end else begin
      tick_cnt_q <= tick_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      trip_q     <= trip_d;
      en_t_q     <= en_t_d;
      dir_t_q    <= dir_t_d;
      dir_q      <= dir_d;
      duty_t_q   <= duty_t_d;
      duty_q     <= duty_d;
    end
  end

  always_comb begin
    busy  = '0;
    rdata = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      busy[c] = (duty_q[c] != duty_t_q[c]) || (dir_q[c] != dir_t_q[c]);
      if (word == 6'(c)) begin
        rdata[0]            = en_t_q[c];
        rdata[1]            = dir_t_q[c];
        rdata[8 +: DUTY_W]  = duty_t_q[c];
      end
    end
    if (st_hit) begin
      rdata[0]           = trip_q;
      rdata[8 +: NUM_CH] = busy;
    end
  end

  always_comb begin
    PWM_DUTY = '0;
    for (int c = 0; c < NUM_CH; c++) PWM_DUTY[c*DUTY_W +: DUTY_W] = duty_q[c];
  end

  assign PWM_EN     = en_t_q;
  assign PWM_DIR    = dir_q;
  assign WDOG_TRIP  = trip_q;
  assign apb.PRDATA = rd_en ? rdata : '0;
  assign apb.PREADY = 1'b1;

`ifdef APB_MOTOR_SLVERR_EN
  logic unmapped;
  assign unmapped    = ~ch_hit & ~st_hit;
  assign apb.PSLVERR = apb.PSEL & apb.PENABLE & (unmapped | (apb.PWRITE & ch_hit & trip_q));
`else
  assign apb.PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_motor_ramp_ctrl.sv
// Scoreboarded bench for apb_motor_ramp_ctrl: directed scenarios plus random APB traffic
// checked every cycle against a behavioural model of the ramp/watchdog rules.
module tb_apb_motor_ramp_ctrl;
  localparam int NUM_CH = 2, DUTY_W = 8, TIMEOUT_CYC = 1000, RAMP_DIV = 4, RAMP_STEP = 8;

  logic        PCLK   = 1'b0;
  logic        PRESET = 1'b0;
  logic [15:0] PWM_DUTY;
  logic [1:0]  PWM_EN, PWM_DIR;
  logic        WDOG_TRIP;

  apb_motor_ramp_if bus();

  apb_motor_ramp_ctrl #(
    .NUM_CH(NUM_CH), .DUTY_W(DUTY_W), .TIMEOUT_CYC(TIMEOUT_CYC),
    .RAMP_DIV(RAMP_DIV), .RAMP_STEP(RAMP_STEP)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .apb(bus),
    .PWM_DUTY(PWM_DUTY), .PWM_EN(PWM_EN), .PWM_DIR(PWM_DIR), .WDOG_TRIP(WDOG_TRIP)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Behavioural model: duties and targets as plain integers.
  int m_duty [2];
  int m_tgt  [2];
  bit m_en   [2];
  bit m_dt   [2];
  bit m_da   [2];
  int m_tick = 0;
  int m_wd   = 0;
  bit m_trip = 1'b0;

  logic [20:0] exp_q [$];
  logic [32:0] acc_q [$];

  task automatic model_clear_channels();
    for (int c = 0; c < NUM_CH; c++) begin
      m_duty[c] = 0; m_tgt[c] = 0; m_en[c] = 0; m_dt[c] = 0; m_da[c] = 0;
    end
  endtask

  task automatic model_step();
    int w;
    bit wr, chw;
    w   = int'(bus.PADDR[7:2]);
    wr  = bus.PSEL && bus.PENABLE && bus.PWRITE;
    chw = wr && (w < NUM_CH) && !m_trip;
    if (m_tick == RAMP_DIV - 1) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (m_da[c] != m_dt[c]) begin
          if (m_duty[c] > 0) m_duty[c] -= min2(RAMP_STEP, m_duty[c]);
          else               m_da[c] = m_dt[c];
        end else if (m_duty[c] < m_tgt[c]) m_duty[c] += min2(RAMP_STEP, m_tgt[c] - m_duty[c]);
        else if (m_duty[c] > m_tgt[c])     m_duty[c] -= min2(RAMP_STEP, m_duty[c] - m_tgt[c]);
      end
    end
    m_tick = (m_tick + 1) % RAMP_DIV;
    for (int c = 0; c < NUM_CH; c++) if (!m_en[c]) m_duty[c] = 0;
    if (chw) begin
      m_en[w]  = bus.PWDATA[0];
      m_dt[w]  = bus.PWDATA[1];
      m_tgt[w] = int'(bus.PWDATA[15:8]);
      if (!m_en[w]) m_duty[w] = 0;
    end
    if (m_trip) begin
      if (wr && w == 15 && bus.PWDATA[0]) begin m_trip = 0; m_wd = 0; end
    end else if (chw) begin
      m_wd = 0;
    end else if (m_wd == TIMEOUT_CYC - 1) begin
      m_trip = 1;
      model_clear_channels();
    end else begin
      m_wd++;
    end
  endtask

  function automatic logic [32:0] m_access(input bit wr, input logic [31:0] addr);
    int w;
    logic [31:0] d;
    bit err;
    w = int'(addr[7:2]);
    d = '0;
    err = 1'b0;
    if (!wr) begin
      if (w < NUM_CH) d = {16'h0, 8'(m_tgt[w]), 6'h0, m_dt[w], m_en[w]};
      else if (w == 15) begin
        d[0] = m_trip;
        for (int c = 0; c < NUM_CH; c++) d[8+c] = (m_duty[c] != m_tgt[c]) || (m_da[c] != m_dt[c]);
      end
    end
`ifdef APB_MOTOR_SLVERR_EN
    err = (w >= NUM_CH && w != 15) || (wr && w < NUM_CH && m_trip);
`endif
    return {err, d};
  endfunction

  always @(posedge PCLK) begin
    if (PRESET) begin
      model_clear_channels();
      m_tick = 0; m_wd = 0; m_trip = 0;
    end else begin
      model_step();
    end
    exp_q.push_back({8'(m_duty[1]), 8'(m_duty[0]), m_en[1], m_en[0], m_da[1], m_da[0], m_trip});
  end

  // Monitor: outputs every cycle, APB response on every access phase.
  logic [20:0] e;
  logic [32:0] a;
  always @(negedge PCLK) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (chk_on && !PRESET) chk("pwm_outputs", {PWM_DUTY, PWM_EN, PWM_DIR, WDOG_TRIP}, 64'(e));
    end
    if (bus.PSEL && bus.PENABLE) begin
      if (acc_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL apb_access: got unexpected access, required a queued expectation");
      end else begin
        a = acc_q.pop_front();
        chk("apb_access", {bus.PREADY, bus.PSLVERR, bus.PRDATA}, {1'b1, a});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that ends the access.
  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                     output logic [31:0] rd, output logic err);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = addr; bus.PWDATA = data;
    step(1);
    bus.PENABLE = 1'b1;
    acc_q.push_back(m_access(wr, addr));
    rd  = bus.PRDATA;
    err = bus.PSLVERR;
    step(1);
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  logic [31:0] rd, addr, data;
  logic        err;
  int          last, w;
  bit          ok, flipped;

  initial begin
    bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = 0; bus.PWDATA = 0;
    #1 PRESET = 1'b1;
    step(3);
    PRESET = 1'b0;
    chk_on = 1'b1;
    chk("reset_outputs", {PWM_DUTY, PWM_EN, PWM_DIR, WDOG_TRIP}, 0);
    chk("reset_prdata_idle", bus.PRDATA, 0);
    apb(0, 32'h3C, 0, rd, err);
    chk("reset_status", rd, 0);

    // Reset in the middle of a ramp.
    apb(1, 32'h0, 32'h0000_C801, rd, err);
    step(12);
    chk("mid_ramp_active", PWM_DUTY[7:0] != 0, 1);
    PRESET = 1'b1;
    step(2);
    PRESET = 1'b0;
    chk("reset_mid_ramp", {PWM_DUTY, PWM_EN, PWM_DIR, WDOG_TRIP}, 0);
    chk("reset_mid_prdata", bus.PRDATA, 0);
    apb(0, 32'h3C, 0, rd, err);
    chk("reset_mid_status", rd, 0);
    apb(0, 32'h0, 0, rd, err);
    chk("reset_mid_ch0", rd, 0);

    // Ramp up to 100 in steps of 8.
    apb(1, 32'h0, 32'h0000_6401, rd, err);
    chk("pwm_en_next", PWM_EN[0], 1);
    last = 0; ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      step(1);
      if (int'(PWM_DUTY[7:0]) != last) begin
        chk("ramp_up_step", PWM_DUTY[7:0], min2(last + 8, 100));
        last = int'(PWM_DUTY[7:0]);
      end
      ok = (last == 100);
    end
    chk("ramp_up_done", ok, 1);
    apb(0, 32'h3C, 0, rd, err);
    chk("busy_clear", rd[15:8], 0);

    // Reverse to 50: down to 0, flip, back up.
    apb(1, 32'h0, 32'h0000_3203, rd, err);
    apb(0, 32'h3C, 0, rd, err);
    chk("busy_set", rd[8], 1);
    last = 100; ok = 0; flipped = 0;
    for (int k = 0; k < 600 && !ok; k++) begin
      step(1);
      if (PWM_DIR[0] && !flipped) begin
        flipped = 1;
        chk("flip_at_zero", {24'(last), PWM_DUTY[7:0]}, 0);
        last = 0;
      end else if (int'(PWM_DUTY[7:0]) != last) begin
        if (!flipped) chk("ramp_down_step", PWM_DUTY[7:0], last - min2(8, last));
        else          chk("ramp_rev_step", PWM_DUTY[7:0], min2(last + 8, 50));
        last = int'(PWM_DUTY[7:0]);
      end
      ok = flipped && (last == 50);
    end
    chk("reverse_done", ok, 1);

    // Watchdog trip after 1000 idle cycles.
    apb(1, 32'h4, 32'h0000_FF01, rd, err);
    step(999);
    chk("wdog_not_yet", WDOG_TRIP, 0);
    step(1);
    chk("wdog_trip", WDOG_TRIP, 1);
    chk("wdog_outputs_off", {PWM_DUTY, PWM_EN, PWM_DIR}, 0);
    apb(1, 32'h4, 32'h0000_FF01, rd, err);
`ifdef APB_MOTOR_SLVERR_EN
    chk("tripped_write_err", err, 1);
`else
    chk("tripped_write_err", err, 0);
`endif
    chk("tripped_write_ignored", PWM_EN, 0);
    apb(0, 32'h4, 0, rd, err);
    chk("tripped_ch1_target", rd, 0);
    apb(1, 32'h3C, 32'h1, rd, err);
    chk("wdog_cleared", WDOG_TRIP, 0);

    // Channel write on the exact cycle the counter sits at its last value.
    for (int k = 0; k < 2000 && m_wd != TIMEOUT_CYC - 2; k++) step(1);
    chk("wdog_align", m_wd, TIMEOUT_CYC - 2);
    apb(1, 32'h0, 32'h0000_6401, rd, err);
    chk("wdog_write_wins", WDOG_TRIP, 0);
    step(999);
    chk("wdog_restart_quiet", WDOG_TRIP, 0);
    step(1);
    chk("wdog_restart_trip", WDOG_TRIP, 1);
    apb(1, 32'h3C, 32'h1, rd, err);

    // Unmapped word.
    apb(0, 32'h14, 0, rd, err);
    chk("unmapped_rdata", rd, 0);
`ifdef APB_MOTOR_SLVERR_EN
    chk("unmapped_err", err, 1);
`else
    chk("unmapped_err", err, 0);
`endif

    // Random traffic.
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          data = $urandom;
          data[0] = ($urandom_range(0, 4) != 0);
          addr = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 1)) << 2);
          apb(1, addr, data, rd, err);
        end
        4, 5, 6: begin
          addr = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 15)) << 2);
          apb(0, addr, 0, rd, err);
        end
        7: apb(1, 32'h3C, $urandom, rd, err);
        8: begin
          w = $urandom_range(2, 63);
          if (w == 15) w = 16;
          apb(1, 32'(w) << 2, $urandom, rd, err);
        end
        default: step($urandom_range(1, 40));
      endcase
    end

    step(5);
    chk("access_queue_drained", acc_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
